// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the multiply/divide unit.
// Holds the md_op operation codes, the sequencer FSM states and the
// operation-kind tag passed from the datapath to the sequencer.
package md_pkg;

    // Operation select codes on md_op; 3'd6 and 3'd7 are undefined and ignored
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2
    } md_state_e;

    // Kind of long-latency operation being launched
    typedef enum logic {
        KIND_MUL = 1'b0,
        KIND_DIV = 1'b1
    } md_kind_e;

    // Two's-complement magnitude of a 32-bit value when neg is set
    function automatic logic [31:0] md_abs32(input logic [31:0] v, input logic neg);
        logic [31:0] res;
        if (neg) begin
            res = (~v) + 32'd1;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/md_seq.sv
// md_seq: IDLE / MUL_RUN / DIV_RUN sequencer with a down-counter.
// An accepted operation loads CYCLES-1 into the counter; the edge on which
// the counter is already zero is the final edge, flagged by o_commit.
// Optional feature macro: MD_UNIT_CANCEL_EN adds i_cancel, which aborts a
// running operation and suppresses the final-edge commit.
module md_seq
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     i_accept,
    input  md_kind_e i_kind,
`ifdef MD_UNIT_CANCEL_EN
    input  logic     i_cancel,
`endif
    output logic     o_busy,
    output logic     o_commit
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             w_cancel;
    logic             w_last;

`ifdef MD_UNIT_CANCEL_EN
    assign w_cancel = i_cancel;
`else
    assign w_cancel = 1'b0;
`endif

    assign w_last   = (r_state != ST_IDLE) && (r_cnt == CNT_ZERO);
    assign o_commit = w_last && !w_cancel;
    assign o_busy   = r_busy;

    // State, counter and busy flag advance together on each clock edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_accept) begin
                        r_state <= (i_kind == KIND_DIV) ? ST_DIV_RUN : ST_MUL_RUN;
                        r_cnt   <= (i_kind == KIND_DIV) ? DIV_LOAD : MUL_LOAD;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                        r_busy  <= 1'b0;
                    end
                end
                ST_MUL_RUN, ST_DIV_RUN: begin
                    if (w_cancel || (r_cnt == CNT_ZERO)) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= CNT_ZERO;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: MIPS-style HI/LO multiply/divide unit.
// MULT/MULTU/DIV/DIVU latch their operands, hold busy for a fixed number of
// cycles and then update {HI,LO} atomically; MTHI/MTLO write in one cycle.
// Divide by zero runs the full duration but leaves HI/LO untouched.
// Optional feature macro: MD_UNIT_CANCEL_EN adds the cancel input.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
`ifdef MD_UNIT_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic        w_busy;
    logic        w_commit;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_is_mv;
    logic        w_accept_md;
    logic        w_accept_mv;
    md_kind_e    w_kind;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_op;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_signed;
    logic        w_neg_a;
    logic        w_neg_b;
    logic        w_b_zero;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Classify the requested operation; undefined codes match nothing
    always_comb begin
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        w_is_mv  = 1'b0;
        case (md_op)
            OP_MULT, OP_MULTU: w_is_mul = 1'b1;
            OP_DIV,  OP_DIVU:  w_is_div = 1'b1;
            OP_MTHI, OP_MTLO:  w_is_mv  = 1'b1;
            default: begin
                w_is_mul = 1'b0;
                w_is_div = 1'b0;
                w_is_mv  = 1'b0;
            end
        endcase
    end

    // Requests are only taken while the sequencer is idle
    assign w_accept_md = start && !w_busy && (w_is_mul || w_is_div);
    assign w_accept_mv = start && !w_busy && w_is_mv;
    assign w_kind      = w_is_div ? KIND_DIV : KIND_MUL;

    md_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_seq (
        .clk      (clk),
        .reset    (reset),
        .i_accept (w_accept_md),
        .i_kind   (w_kind),
`ifdef MD_UNIT_CANCEL_EN
        .i_cancel (cancel),
`endif
        .o_busy   (w_busy),
        .o_commit (w_commit)
    );

    // Capture operands and operation on the accepting edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a  <= 32'd0;
            r_b  <= 32'd0;
            r_op <= 3'd0;
        end else if (w_accept_md) begin
            r_a  <= A;
            r_b  <= B;
            r_op <= md_op;
        end else begin
            r_a  <= r_a;
            r_b  <= r_b;
            r_op <= r_op;
        end
    end

    // 64-bit products from the latched operands
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend; 0x80000000 / -1 wraps to 0x80000000
    assign w_div_signed = (r_op == OP_DIV);
    assign w_neg_a      = w_div_signed && r_a[31];
    assign w_neg_b      = w_div_signed && r_b[31];
    assign w_b_zero     = (r_b == 32'd0);
    assign w_mag_a      = md_abs32(r_a, w_neg_a);
    assign w_mag_b      = md_abs32(r_b, w_neg_b);
    assign w_divisor    = w_b_zero ? 32'd1 : w_mag_b;
    assign w_q_mag      = w_mag_a / w_divisor;
    assign w_r_mag      = w_mag_a % w_divisor;
    assign w_quot       = md_abs32(w_q_mag, w_neg_a ^ w_neg_b);
    assign w_rem        = md_abs32(w_r_mag, w_neg_a);

    // Architectural HI/LO: atomic update on the final edge or a move
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            case (r_op)
                OP_MULT: begin
                    r_hi <= w_prod_s[63:32];
                    r_lo <= w_prod_s[31:0];
                end
                OP_MULTU: begin
                    r_hi <= w_prod_u[63:32];
                    r_lo <= w_prod_u[31:0];
                end
                OP_DIV, OP_DIVU: begin
                    if (!w_b_zero) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= r_hi;
                        r_lo <= r_lo;
                    end
                end
                default: begin
                    r_hi <= r_hi;
                    r_lo <= r_lo;
                end
            endcase
        end else if (w_accept_mv) begin
            if (md_op == OP_MTHI) begin
                r_hi <= A;
            end else begin
                r_lo <= A;
            end
        end else begin
            r_hi <= r_hi;
            r_lo <= r_lo;
        end
    end

    assign busy = w_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit with a 64-bit arithmetic
// reference model. Build with MD_UNIT_CANCEL_EN defined to include the
// cancel scenario.
module tb_md_unit;
    import md_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
`ifdef MD_UNIT_CANCEL_EN
    logic        cancel;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    md_unit #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
`ifdef MD_UNIT_CANCEL_EN
        .cancel(cancel),
`endif
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference semantics using 64-bit integer arithmetic
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      pa;
        longint      pb;
        longint      q;
        longint      r;
        logic [63:0] p;
        case (op)
            3'd0: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd2: begin
                if (b != 32'd0) begin
                    pa = longint'($signed(a));
                    pb = longint'($signed(b));
                    q = pa / pb;
                    r = pa % pb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            3'd3: begin
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue a multiply/divide, optionally poke a stray start at busy cycle ignore_at
    task automatic do_muldiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int ignore_at, input string name);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          n;
        old_hi = m_hi;
        old_lo = m_lo;
        n = (op == 3'd2 || op == 3'd3) ? DC : MC;
        start = 1'b1; md_op = op; A = a; B = b;
        tick();
        start = 1'b0; A = $urandom; B = $urandom; md_op = 3'($urandom_range(0, 7));
        for (int c = 1; c <= n; c++) begin
            checks++;
            if (busy !== 1'b1 || HI !== old_hi || LO !== old_lo) begin
                failures++;
                $display("FAIL %s inflight cycle %0d: busy=%b HI=%h LO=%h expected busy=1 HI=%h LO=%h",
                         name, c, busy, HI, LO, old_hi, old_lo);
            end
            if (c == ignore_at) begin
                start = 1'b1;
                md_op = 3'($urandom_range(0, 5));
                A = $urandom; B = $urandom;
            end
            tick();
            start = 1'b0;
        end
        model_apply(op, a, b);
        checks++;
        if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
            failures++;
            $display("FAIL %s result: busy=%b HI=%h LO=%h expected busy=0 HI=%h LO=%h",
                     name, busy, HI, LO, m_hi, m_lo);
        end
    endtask

    task automatic do_move(input logic [2:0] op, input logic [31:0] a, input string name);
        start = 1'b1; md_op = op; A = a; B = $urandom;
        tick();
        start = 1'b0; A = $urandom;
        model_apply(op, a, 32'd0);
        checks++;
        if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
            failures++;
            $display("FAIL %s: busy=%b HI=%h LO=%h expected busy=0 HI=%h LO=%h",
                     name, busy, HI, LO, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
`ifdef MD_UNIT_CANCEL_EN
        cancel = 1'b0;
`endif
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: busy=%b HI=%h LO=%h expected 0/0/0", busy, HI, LO);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        do_muldiv(3'd0, 32'hFFFFFFFF, 32'd2, 0, "mult_neg1x2");
        checks++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFE) begin
            failures++;
            $display("FAIL mult_const: HI=%h LO=%h expected ffffffff/fffffffe", HI, LO);
        end
        do_muldiv(3'd1, 32'hFFFFFFFF, 32'd2, 0, "multu_max_x2");
        checks++;
        if (HI !== 32'h00000001 || LO !== 32'hFFFFFFFE) begin
            failures++;
            $display("FAIL multu_const: HI=%h LO=%h expected 00000001/fffffffe", HI, LO);
        end
        do_muldiv(3'd2, 32'hFFFFFFF9, 32'd2, 3, "div_m7_by_2");
        checks++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
            failures++;
            $display("FAIL div_const: HI=%h LO=%h expected ffffffff/fffffffd", HI, LO);
        end
        do_move(3'd5, 32'd0, "mtlo_zero");
        do_move(3'd4, 32'h12345678, "mthi");
        do_muldiv(3'd3, 32'd55, 32'd0, 0, "divu_by_zero");
        checks++;
        if (HI !== 32'h12345678 || LO !== 32'd0) begin
            failures++;
            $display("FAIL divzero_const: HI=%h LO=%h expected 12345678/00000000", HI, LO);
        end
        do_muldiv(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, "div_overflow");
        checks++;
        if (HI !== 32'd0 || LO !== 32'h80000000) begin
            failures++;
            $display("FAIL div_overflow_const: HI=%h LO=%h expected 00000000/80000000", HI, LO);
        end
    endtask

    task automatic test_invalid_op();
        for (int i = 6; i <= 7; i++) begin
            start = 1'b1; md_op = 3'(i); A = $urandom; B = $urandom;
            tick();
            start = 1'b0;
            checks++;
            if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
                failures++;
                $display("FAIL invalid_op %0d: busy=%b HI=%h LO=%h expected busy=0 HI=%h LO=%h",
                         i, busy, HI, LO, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_muldiv(3'd1, 32'd7, 32'd9, 0, "b2b_multu");
        do_muldiv(3'd2, 32'd100, 32'hFFFFFFFD, 0, "b2b_div");
        do_muldiv(3'd0, 32'h80000000, 32'h80000000, 0, "b2b_mult");
        do_move(3'd5, 32'hCAFEF00D, "b2b_mtlo");
        do_muldiv(3'd3, 32'hFFFFFFFF, 32'd16, 2, "b2b_divu");
    endtask

    task automatic test_reset_abort();
        do_move(3'd4, 32'hAAAA5555, "abort_mthi");
        start = 1'b1; md_op = 3'd3; A = 32'd100; B = 32'd7;
        tick();
        start = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            failures++;
            $display("FAIL reset_abort_now: busy=%b HI=%h LO=%h expected 0/0/0", busy, HI, LO);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < DC + 2; c++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
                failures++;
                $display("FAIL reset_abort_later cycle %0d: busy=%b HI=%h LO=%h expected 0/0/0",
                         c, busy, HI, LO);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 50; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 9));
                default: b = 32'($urandom);
            endcase
            if (op <= 3'd3) begin
                do_muldiv(op, a, b, ($urandom_range(0, 1) == 1) ? 2 : 0, "random_md");
            end else if (op <= 3'd5) begin
                do_move(op, a, "random_move");
            end else begin
                start = 1'b1; md_op = op; A = a; B = b;
                tick();
                start = 1'b0;
                checks++;
                if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
                    failures++;
                    $display("FAIL random_invalid: busy=%b HI=%h LO=%h expected busy=0 HI=%h LO=%h",
                             busy, HI, LO, m_hi, m_lo);
                end
            end
        end
    endtask

`ifdef MD_UNIT_CANCEL_EN
    task automatic test_cancel();
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        start = 1'b1; md_op = 3'd0; A = 32'd3; B = 32'd4;
        tick();
        start = 1'b0;
        for (int c = 1; c <= MC; c++) begin
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL cancel_busy cycle %0d: busy=%b expected 1", c, busy);
            end
            if (c == MC) cancel = 1'b1;
            tick();
            cancel = 1'b0;
        end
        checks++;
        if (busy !== 1'b0 || HI !== old_hi || LO !== old_lo) begin
            failures++;
            $display("FAIL cancel_result: busy=%b HI=%h LO=%h expected busy=0 HI=%h LO=%h",
                     busy, HI, LO, old_hi, old_lo);
        end
        do_muldiv(3'd0, 32'd3, 32'd4, 0, "after_cancel_mult");
        checks++;
        if (LO !== 32'd12 || HI !== 32'd0) begin
            failures++;
            $display("FAIL after_cancel_const: HI=%h LO=%h expected 00000000/0000000c", HI, LO);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_invalid_op();
        test_back_to_back();
        test_reset_abort();
        test_random();
`ifdef MD_UNIT_CANCEL_EN
        test_cancel();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy duration in cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy duration in cycles for DIV/DIVU.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: request to issue the operation on md_op this cycle.
REQ-006 SHALL have port md_op, input, 3: operation select: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 SHALL have port A, input, 32: first operand (GRF rs read data).
REQ-008 SHALL have port B, input, 32: second operand (GRF rt read data).
REQ-009 SHALL have port busy, output, 1: high while a multiply or divide is in flight.
REQ-010 SHALL have port HI, output, 32: architectural HI register.
REQ-011 SHALL have port LO, output, 32: architectural LO register.

Function
REQ-012 SHALL implement an FSM with states IDLE, MUL_RUN and DIV_RUN, plus a down-counter.
REQ-013 SHALL accept start only in IDLE; start while busy=1 SHALL be ignored, with no effect on state, HI or LO.
REQ-014 SHALL latch A, B and md_op on the accepting edge; later operand changes have no effect on the result.
REQ-015 On accepted MULT/MULTU at edge k: busy=1 after edge k; {HI,LO} = 64-bit signed/unsigned product, written at edge k+MULT_CYCLES; busy=0 after that same edge.
REQ-016 On accepted DIV/DIVU at edge k: LO = quotient and HI = remainder (signed: truncation toward zero, remainder takes dividend sign), written at edge k+DIV_CYCLES; busy=0 after that edge.
REQ-017 SHALL accept MTHI/MTLO in IDLE and complete them in one cycle: HI or LO = A at the accepting edge; busy stays 0.
REQ-018 Divide by zero (B=0) SHALL still run DIV_CYCLES with busy=1 and SHALL leave HI and LO unchanged.
REQ-019 Signed DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000.
REQ-020 HI and LO SHALL hold their old values throughout an in-flight operation; the update is atomic at the final edge.
REQ-021 A new start in the cycle immediately after busy falls SHALL be accepted (back-to-back issue, no gap).
REQ-022 md_op codes outside the six defined values SHALL be ignored even when start=1.

Reset
REQ-023 reset=0 SHALL asynchronously force: HI=0, LO=0, busy=0, state=IDLE, counter=0.
REQ-024 reset asserted mid-operation SHALL abort the operation; no result is ever written.

Configuration
REQ-025 Macro MD_UNIT_CANCEL_EN defined: port cancel (input, 1) SHALL exist; cancel=1 SHALL return the FSM to IDLE and set busy=0 at the next edge, with HI/LO unchanged, and SHALL take priority over a final-cycle write.
REQ-026 MD_UNIT_CANCEL_EN undefined: the cancel port and its logic SHALL be absent; an operation always runs to completion.

Structure
REQ-027 The md_op encodings and FSM state encodings SHALL live in shared package md_pkg.
REQ-028 The FSM and counter SHALL be a sub-module md_seq (inputs: accepted/kind/cancel; outputs: busy, commit pulse); the datapath stays in md_unit.

Verification
REQ-029 MULT with A=0xFFFFFFFF, B=2 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-030 MULTU with A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
REQ-031 DIV with A=-7, B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; a second start at cycle 3 is ignored.
REQ-032 MTHI A=0x12345678, then DIVU with B=0 -> HI stays 0x12345678 and LO stays 0 after 10 busy cycles.
REQ-033 reset pulled low at cycle 2 of DIVU 100/7 -> busy=0 and HI=LO=0 immediately; no later update occurs.
REQ-034 With MD_UNIT_CANCEL_EN: MULT 3*4 with cancel at cycle 5 -> HI/LO unchanged, busy=0; an immediate MULT 3*4 then gives LO=12.
